hazard_tracker: RTL and testbench
=================================

# hazard_tracker

Producer side of the EX/MEM and MEM/WB operand-forwarding interface. Carries each decoded instruction's register fields (rs, rt, rd, RegWrite, MemRead) through the ID/EX, EX/MEM and MEM/WB pipeline registers. Supplies the stage-tagged destination and RegWrite signals that the forwarding logic compares against. Also detects hazards that forwarding cannot cover (load-use, multi-cycle memory wait, branch flush) and emits the stall/freeze controls for the rest of the datapath.

## Interface
Parameters:
- MAX_WAIT, default 15: memory wait cycles tolerated before mem_error is raised (1..255).

Ports:
- Clocking: one clock; reset is asynchronous and active-low. Ports are named clk and rst_n.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ID_valid  in  1  IF/ID holds a real instruction
- ID_rs, ID_rt, ID_rd  in  5 each  decoded register fields
- ID_RegWrite, ID_MemRead  in  1 each  decoded controls
- branch_flush  in  1  branch resolved taken in EX; squash younger instructions
- mem_ready  in  1  data memory completes the access in MEM this cycle
- ID_EX_rs, ID_EX_rt  out  5 each  to forwarding logic
- EX_MEM_rd, MEM_WB_rd  out  5 each  to forwarding logic
- EX_MEM_RegWrite, MEM_WB_RegWrite  out  1 each  to forwarding logic
- stall  out  1  hold PC and IF/ID
- freeze  out  1  hold all pipeline registers, including external datapath ones
- mem_error  out  1  sticky; memory wait exceeded MAX_WAIT
- stall_cycles  out  16  saturating stall+freeze cycle count (see Configuration)

## Operation
- Internal stage registers:
  - ID/EX: rs, rt, rd, RegWrite, MemRead.
  - EX/MEM: rd, RegWrite, MemRead.
  - MEM/WB: rd, RegWrite.
- Bubble: every field of the stage register cleared to 0.
- Load-use hazard (combinational), all of the following true:
  - ID_valid;
  - ID/EX MemRead and RegWrite;
  - ID/EX rd != 0;
  - ID/EX rd equals ID_rs or ID_rt.
- Memory wait: EX/MEM MemRead = 1 and mem_ready = 0.
- FSM with two states: RUN and MEM_WAIT.
  - RUN to MEM_WAIT: on any edge where the memory-wait condition holds.
  - MEM_WAIT to RUN: on the edge where mem_ready = 1.
  - freeze = 1 whenever the memory-wait condition holds combinationally (from the first wait cycle onward).
- Priority on each edge, highest first:
  1. freeze: all three stage registers hold. Repeated MEM/WB write is idempotent.
  2. branch_flush: ID/EX loads a bubble; EX/MEM and MEM/WB advance normally.
  3. Load-use: ID/EX loads a bubble; stall = 1; later stages advance.
  4. Otherwise: ID/EX loads the ID fields (bubble if ID_valid = 0), EX/MEM takes ID/EX, MEM/WB takes EX/MEM.
- stall = load-use OR freeze. stall is not asserted for branch_flush alone.
- Load-use stall lasts exactly one cycle. Afterwards the load sits in EX/MEM and forwarding covers the dependency.
- Wait counter: 8-bit.
  - Cleared in RUN.
  - Increments each MEM_WAIT cycle, saturating at MAX_WAIT.
  - When the counter reaches MAX_WAIT, mem_error sets and stays set until reset. The pipeline keeps waiting.
- Register 0 is never reported as a write target: rd == 0 forces the stored RegWrite to 0 on capture.

## Timing
- Reset (async assert, sync release):
  - All stage registers 0 and FSM in RUN.
  - All outputs 0: stall, freeze, mem_error, stall_cycles, every rd/rs/rt and every RegWrite.
- Stage advance latency: 1 cycle per stage. An ID instruction appears on EX_MEM_rd two edges after capture, absent stalls.
- stall and freeze are combinational from current state and inputs, valid in the same cycle.
- mem_ready sampled only while a load occupies EX/MEM; ignored otherwise.
- mem_ready high on the first MEM cycle: no freeze and no MEM_WAIT entry.
- branch_flush during freeze: ignored. The source must hold it until freeze drops.
- Reset mid-MEM_WAIT: immediate return to RUN with counter and mem_error cleared.

## Configuration
- HAZARD_STATS_EN defined: stall_cycles increments on every cycle with stall = 1, saturating at 0xFFFF; cleared only by reset.
- HAZARD_STATS_EN undefined: the port remains and is tied to 0; no counter logic is built.

## Test plan
- Load into r5, then add using r5 as rs:
  - stall = 1 for exactly 1 cycle;
  - ID/EX bubble appears (ID_EX_rs = 0);
  - next cycle EX_MEM_rd = 5 with EX_MEM_RegWrite = 1.
- Load with rd = 0 followed by a use of r0: no stall; the load's EX_MEM_RegWrite stays 0.
- Load in MEM with mem_ready held low 3 cycles:
  - freeze = stall = 1 for 3 cycles;
  - EX_MEM_rd and MEM_WB_rd are unchanged across them;
  - everything resumes on the 4th edge.
- MAX_WAIT = 4, mem_ready held low 10 cycles: mem_error rises after 4 wait cycles and stays 1 after mem_ready returns.
- branch_flush together with a load-use condition: ID/EX bubble, stall = 0, no extra stall cycle afterwards.
- rst_n pulsed low during MEM_WAIT: all outputs 0 immediately; with HAZARD_STATS_EN, stall_cycles reads 0.

Source files
------------

// File: rtl/hazard_tracker.sv
// hazard_tracker: carries decoded register fields through ID/EX, EX/MEM and
// MEM/WB, feeds the forwarding unit, and raises stall/freeze for hazards
// that forwarding cannot cover (load-use, memory wait, branch flush).
// Optional feature macro: HAZARD_STATS_EN (builds the stall_cycles counter;
// otherwise stall_cycles is tied to 0).
module hazard_tracker #(
  parameter int MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ID_valid,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic [4:0] ID_rd,
  input  logic       ID_RegWrite,
  input  logic       ID_MemRead,
  input  logic       branch_flush,
  input  logic       mem_ready,
  output logic [4:0] ID_EX_rs,
  output logic [4:0] ID_EX_rt,
  output logic [4:0] EX_MEM_rd,
  output logic [4:0] MEM_WB_rd,
  output logic       EX_MEM_RegWrite,
  output logic       MEM_WB_RegWrite,
  output logic       stall,
  output logic       freeze,
  output logic       mem_error,
  output logic [15:0] stall_cycles
);

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  // Stage registers and their next values
  logic [4:0] idex_rs_reg, idex_rt_reg, idex_rd_reg;
  logic       idex_rw_reg, idex_mr_reg;
  logic [4:0] exmem_rd_reg;
  logic       exmem_rw_reg, exmem_mr_reg;
  logic [4:0] memwb_rd_reg;
  logic       memwb_rw_reg;

  logic [4:0] idex_rs_next, idex_rt_next, idex_rd_next;
  logic       idex_rw_next, idex_mr_next;
  logic [4:0] exmem_rd_next;
  logic       exmem_rw_next, exmem_mr_next;
  logic [4:0] memwb_rd_next;
  logic       memwb_rw_next;

  state_t     state_reg, state_next;
  logic [7:0] wait_cnt_reg, wait_cnt_next;
  logic       mem_error_reg, mem_error_next;

  logic load_use;
  logic load_use_stall;
  logic mem_wait;

  // Hazard detection: a load in EX whose destination is read by the ID instruction
  always_comb begin
    load_use = ID_valid && idex_mr_reg && idex_rw_reg && (idex_rd_reg != 5'd0) &&
               ((idex_rd_reg == ID_rs) || (idex_rd_reg == ID_rt));
    mem_wait = exmem_mr_reg && !mem_ready;
    // A taken branch squashes the dependent instruction, so no stall is needed
    load_use_stall = load_use && !branch_flush;
  end

  // Stage-register next values, priority: freeze, flush, load-use, advance
  always_comb begin
    idex_rs_next  = idex_rs_reg;
    idex_rt_next  = idex_rt_reg;
    idex_rd_next  = idex_rd_reg;
    idex_rw_next  = idex_rw_reg;
    idex_mr_next  = idex_mr_reg;
    exmem_rd_next = exmem_rd_reg;
    exmem_rw_next = exmem_rw_reg;
    exmem_mr_next = exmem_mr_reg;
    memwb_rd_next = memwb_rd_reg;
    memwb_rw_next = memwb_rw_reg;
    if (!mem_wait) begin
      exmem_rd_next = idex_rd_reg;
      exmem_rw_next = idex_rw_reg;
      exmem_mr_next = idex_mr_reg;
      memwb_rd_next = exmem_rd_reg;
      memwb_rw_next = exmem_rw_reg;
      if (branch_flush || load_use || !ID_valid) begin
        idex_rs_next = 5'd0;
        idex_rt_next = 5'd0;
        idex_rd_next = 5'd0;
        idex_rw_next = 1'b0;
        idex_mr_next = 1'b0;
      end else begin
        idex_rs_next = ID_rs;
        idex_rt_next = ID_rt;
        idex_rd_next = ID_rd;
        // r0 is never a write target, so forwarding never matches on it
        idex_rw_next = ID_RegWrite && (ID_rd != 5'd0);
        idex_mr_next = ID_MemRead;
      end
    end
  end

  // Stage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_rs_reg  <= 5'd0;
      idex_rt_reg  <= 5'd0;
      idex_rd_reg  <= 5'd0;
      idex_rw_reg  <= 1'b0;
      idex_mr_reg  <= 1'b0;
      exmem_rd_reg <= 5'd0;
      exmem_rw_reg <= 1'b0;
      exmem_mr_reg <= 1'b0;
      memwb_rd_reg <= 5'd0;
      memwb_rw_reg <= 1'b0;
    end else begin
      idex_rs_reg  <= idex_rs_next;
      idex_rt_reg  <= idex_rt_next;
      idex_rd_reg  <= idex_rd_next;
      idex_rw_reg  <= idex_rw_next;
      idex_mr_reg  <= idex_mr_next;
      exmem_rd_reg <= exmem_rd_next;
      exmem_rw_reg <= exmem_rw_next;
      exmem_mr_reg <= exmem_mr_next;
      memwb_rd_reg <= memwb_rd_next;
      memwb_rw_reg <= memwb_rw_next;
    end
  end

  // Memory-wait FSM next state, wait counter and sticky error
  always_comb begin
    state_next     = state_reg;
    wait_cnt_next  = 8'd0;
    mem_error_next = mem_error_reg;
    case (state_reg)
      RUN:      if (mem_wait)  state_next = MEM_WAIT;
      MEM_WAIT: if (mem_ready) state_next = RUN;
      default:  state_next = RUN;
    endcase
    // Counts every cycle the load is held in MEM, including the first one
    // (which is still spent in RUN); idle RUN cycles keep it at zero.
    if (mem_wait) begin
      wait_cnt_next = (wait_cnt_reg >= MAX_W) ? MAX_W : wait_cnt_reg + 8'd1;
      if (wait_cnt_next == MAX_W) mem_error_next = 1'b1;
    end
  end

  // FSM state, counter and error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= RUN;
      wait_cnt_reg  <= 8'd0;
      mem_error_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wait_cnt_reg  <= wait_cnt_next;
      mem_error_reg <= mem_error_next;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_reg;

  // Saturating count of cycles with stall asserted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= 16'd0;
    end else if (stall && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cycles = stall_cnt_reg;
`else
  assign stall_cycles = 16'd0;
`endif

  assign freeze          = mem_wait;
  assign stall           = load_use_stall || mem_wait;
  assign mem_error       = mem_error_reg;
  assign ID_EX_rs        = idex_rs_reg;
  assign ID_EX_rt        = idex_rt_reg;
  assign EX_MEM_rd       = exmem_rd_reg;
  assign EX_MEM_RegWrite = exmem_rw_reg;
  assign MEM_WB_rd       = memwb_rd_reg;
  assign MEM_WB_RegWrite = memwb_rw_reg;

endmodule

// File: tb/tb_hazard_tracker.sv
// Self-checking bench for hazard_tracker (MAX_WAIT = 4). Each cycle's
// expected outputs are pushed to a scoreboard queue when stimulus is driven
// and popped/compared just before the next rising edge.
module tb_hazard_tracker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ID_valid = 1'b0;
  logic [4:0] ID_rs = '0, ID_rt = '0, ID_rd = '0;
  logic       ID_RegWrite = 1'b0, ID_MemRead = 1'b0;
  logic       branch_flush = 1'b0;
  logic       mem_ready = 1'b1;
  logic [4:0] ID_EX_rs, ID_EX_rt, EX_MEM_rd, MEM_WB_rd;
  logic       EX_MEM_RegWrite, MEM_WB_RegWrite;
  logic       stall, freeze, mem_error;
  logic [15:0] stall_cycles;

  hazard_tracker #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_valid(ID_valid), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_rd(ID_rd),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead),
    .branch_flush(branch_flush), .mem_ready(mem_ready),
    .ID_EX_rs(ID_EX_rs), .ID_EX_rt(ID_EX_rt),
    .EX_MEM_rd(EX_MEM_rd), .MEM_WB_rd(MEM_WB_rd),
    .EX_MEM_RegWrite(EX_MEM_RegWrite), .MEM_WB_RegWrite(MEM_WB_RegWrite),
    .stall(stall), .freeze(freeze), .mem_error(mem_error),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic       fz;
    logic [4:0] idrs;
    logic [4:0] exrd;
    logic [4:0] mwrd;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   stall_seen = 0;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Pop the oldest expectation and compare it with the DUT outputs.
  // In this sequence every RegWrite flag is set exactly when its rd is non-zero.
  task automatic score();
    exp_t e;
    logic [15:0] exp_sc;
    e = exp_q.pop_front();
`ifdef HAZARD_STATS_EN
    exp_sc = 16'(stall_seen);
`else
    exp_sc = 16'd0;
`endif
    check_val("stall", 16'(stall), 16'(e.st));
    check_val("freeze", 16'(freeze), 16'(e.fz));
    check_val("id_ex_rs", 16'(ID_EX_rs), 16'(e.idrs));
    check_val("ex_mem_rd", 16'(EX_MEM_rd), 16'(e.exrd));
    check_val("ex_mem_rw", 16'(EX_MEM_RegWrite), 16'(e.exrd != 5'd0));
    check_val("mem_wb_rd", 16'(MEM_WB_rd), 16'(e.mwrd));
    check_val("mem_wb_rw", 16'(MEM_WB_RegWrite), 16'(e.mwrd != 5'd0));
    check_val("mem_error", 16'(mem_error), 16'(e.err));
    check_val("stall_cycles", stall_cycles, exp_sc);
    if (e.st) stall_seen++;
    $display("cyc t=%0t stall=%0b freeze=%0b idex_rs=%0d exmem_rd=%0d memwb_rd=%0d err=%0b",
             $time, stall, freeze, ID_EX_rs, EX_MEM_rd, MEM_WB_rd, mem_error);
  endtask

  // One clock cycle: drive ID/control inputs, record expectations, score.
  task automatic cyc(input logic v, input int rs, input int rt, input int rd,
                     input logic rw, input logic mr, input logic fl, input logic rdy,
                     input logic st, input logic fz, input int idrs,
                     input int exrd, input int mwrd, input logic err);
    exp_t e;
    @(negedge clk);
    ID_valid = v; ID_rs = 5'(rs); ID_rt = 5'(rt); ID_rd = 5'(rd);
    ID_RegWrite = rw; ID_MemRead = mr; branch_flush = fl; mem_ready = rdy;
    e.st = st; e.fz = fz; e.idrs = 5'(idrs); e.exrd = 5'(exrd); e.mwrd = 5'(mwrd); e.err = err;
    exp_q.push_back(e);
    #4;
    score();
  endtask

  task automatic idle(input logic rdy, input logic st, input logic fz, input int idrs,
                      input int exrd, input int mwrd, input logic err);
    cyc(0, 0, 0, 0, 0, 0, 0, rdy, st, fz, idrs, exrd, mwrd, err);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_stall"}, 16'(stall), 16'd0);
    check_val({tag, "_freeze"}, 16'(freeze), 16'd0);
    check_val({tag, "_err"}, 16'(mem_error), 16'd0);
    check_val({tag, "_sc"}, stall_cycles, 16'd0);
    check_val({tag, "_idex_rs"}, 16'(ID_EX_rs), 16'd0);
    check_val({tag, "_idex_rt"}, 16'(ID_EX_rt), 16'd0);
    check_val({tag, "_exmem"}, 16'({EX_MEM_rd, EX_MEM_RegWrite}), 16'd0);
    check_val({tag, "_memwb"}, 16'({MEM_WB_rd, MEM_WB_RegWrite}), 16'd0);
  endtask

  initial begin
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Load r5 then use r5: one stall, bubble, load reaches EX/MEM
    cyc(1, 1, 5, 5, 1, 1, 0, 1,  0, 0, 0, 0, 0, 0);
    cyc(1, 5, 2, 6, 1, 0, 0, 1,  1, 0, 1, 0, 0, 0);
    cyc(1, 5, 2, 6, 1, 0, 0, 1,  0, 0, 0, 5, 0, 0);
    idle(1, 0, 0, 5, 0, 5, 0);
    idle(1, 0, 0, 0, 6, 0, 0);

    // Load into r0 then use r0: no stall, RegWrite suppressed
    cyc(1, 1, 0, 0, 1, 1, 0, 1,  0, 0, 0, 0, 6, 0);
    cyc(1, 0, 0, 7, 1, 0, 0, 1,  0, 0, 1, 0, 0, 0);
    idle(1, 0, 0, 0, 0, 0, 0);
    idle(1, 0, 0, 0, 7, 0, 0);

    // Load r9 waits 3 cycles in MEM; flush during freeze is ignored
    cyc(1, 2, 9, 9, 1, 1, 0, 1,  0, 0, 0, 0, 7, 0);
    cyc(1, 3, 4, 10, 1, 0, 0, 1, 0, 0, 2, 0, 0, 0);
    idle(0, 1, 1, 3, 9, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0,  1, 1, 3, 9, 0, 0);
    idle(0, 1, 1, 3, 9, 0, 0);
    idle(1, 0, 0, 3, 9, 0, 0);
    idle(1, 0, 0, 0, 10, 9, 0);

    // Branch flush together with a load-use condition
    cyc(1, 1, 5, 5, 1, 1, 0, 1,  0, 0, 0, 0, 10, 0);
    cyc(1, 5, 2, 6, 1, 0, 1, 1,  0, 0, 1, 0, 0, 0);
    idle(1, 0, 0, 0, 5, 0, 0);
    idle(1, 0, 0, 0, 0, 5, 0);

    // Load r8 waits 10 cycles: mem_error after the 4th wait cycle, sticky
    cyc(1, 1, 8, 8, 1, 1, 0, 1,  0, 0, 0, 0, 0, 0);
    idle(1, 0, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 10; k++) idle(0, 1, 1, 0, 8, 0, (k >= 5));
    idle(1, 0, 0, 0, 8, 0, 1);
    idle(1, 0, 0, 0, 0, 8, 1);

    // Reset pulsed while waiting in MEM
    cyc(1, 1, 3, 3, 1, 1, 0, 1,  0, 0, 0, 0, 0, 1);
    idle(1, 0, 0, 1, 0, 0, 1);
    idle(0, 1, 1, 0, 3, 0, 1);
    idle(0, 1, 1, 0, 3, 0, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    $display("cyc t=%0t async reset during MEM_WAIT", $time);
    stall_seen = 0;
    #2;
    rst_n = 1'b1;
    idle(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 4, 4, 1, 1, 0, 1,  0, 0, 0, 0, 0, 0);
    cyc(1, 2, 4, 6, 1, 0, 0, 1,  1, 0, 1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
